// File: rtl/sizing_pkg.sv
// Shared width helpers for storage primitives: how many bits it takes to
// address N entries, and how many bits it takes to hold the value N itself.
package sizing;

  // Bits needed to address entries 0..n-1; never less than one bit.
  function automatic int encoding_size(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

  // Bits needed to represent the value n (0..n inclusive); never less than one bit.
  function automatic int bit_size(input int n);
    if (n < 1) return 1;
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides.
// Works for any positive depth: pointers wrap explicitly at DEPTH-1 rather
// than relying on binary rollover. Flags come from the registered occupancy
// count only, so in_ready has no combinational path from out_ready.
module sync_fifo
  import sizing::*;
#(
  parameter int  DATA_W       = 8,
  parameter int  DEPTH        = 16,
  parameter int  AFULL_THRESH = DEPTH,
  localparam int AW           = encoding_size(DEPTH),
  localparam int CW           = bit_size(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     count,
  output logic              almost_full
);

  // Elaboration-time sanity checks on the parameter set.
  if (DEPTH < 1) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be >= 1");
  end
  if (DATA_W < 1) begin : g_bad_width
    $error("sync_fifo: DATA_W must be >= 1");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
    $error("sync_fifo: AFULL_THRESH must be in 1..DEPTH");
  end

  // Advance a pointer, wrapping from DEPTH-1 back to 0 (non-power-of-two safe).
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) return '0;
    return p + AW'(1);
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q,  count_d;
  logic              push, pop;

  assign in_ready    = (count_q != CW'(DEPTH));
  assign out_valid   = (count_q != '0);
  assign out_data    = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = (count_q >= CW'(AFULL_THRESH));

  assign push = in_valid  && in_ready;
  assign pop  = out_valid && out_ready;

  // Next-state for pointers and occupancy from the accepted handshakes.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: cleared immediately by reset, contents are simply abandoned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo at DATA_W=12, DEPTH=5, AFULL_THRESH=4:
// reset, fill, drain, wrap, full-with-pop and mid-operation reset.
module tb_sync_fifo;

  localparam int DATA_W = 12;
  localparam int DEPTH  = 5;
  localparam int THRESH = 4;
  localparam int CW     = 3;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     count;
  logic              almost_full;

  int n_checks;
  int n_fails;

  sync_fifo #(
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (THRESH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, report a line, flag mismatches.
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int fill_cnt [6] = '{1, 2, 3, 4, 5, 5};
  int fill_af  [6] = '{0, 0, 0, 1, 1, 1};
  int fill_rdy [6] = '{1, 1, 1, 1, 0, 0};
  int drain_cnt[5] = '{4, 3, 2, 1, 0};
  int drain_af [5] = '{1, 0, 0, 0, 0};
  int tail_exp [4] = '{'h10B, 'h200, 'h201, 'h202};

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    check_eq("rst in_ready",    32'(in_ready),    32'd1);
    check_eq("rst out_valid",   32'(out_valid),   32'd0);
    check_eq("rst count",       32'(count),       32'd0);
    check_eq("rst almost_full", 32'(almost_full), 32'd0);

    // Fill 0x001..0x006 with the consumer stalled
    for (int i = 0; i < 6; i++) begin
      in_data  = DATA_W'(i + 1);
      in_valid = 1'b1;
      step();
      check_eq($sformatf("fill%0d count", i + 1), 32'(count), 32'(fill_cnt[i]));
      check_eq($sformatf("fill%0d afull", i + 1), 32'(almost_full), 32'(fill_af[i]));
      check_eq($sformatf("fill%0d in_ready", i + 1), 32'(in_ready), 32'(fill_rdy[i]));
    end
    in_valid = 1'b0;

    // Drain continuously
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("drain%0d out_valid", k), 32'(out_valid), 32'd1);
      check_eq($sformatf("drain%0d out_data", k), 32'(out_data), 32'(k + 1));
      step();
      check_eq($sformatf("drain%0d count", k), 32'(count), 32'(drain_cnt[k]));
      check_eq($sformatf("drain%0d afull", k), 32'(almost_full), 32'(drain_af[k]));
    end
    check_eq("drained out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Wrap: preload two words, then 12 cycles of simultaneous push/pop
    for (int i = 0; i < 2; i++) begin
      in_data  = DATA_W'('hA0 + i);
      in_valid = 1'b1;
      step();
    end
    check_eq("preload count", 32'(count), 32'd2);
    out_ready = 1'b1;
    for (int j = 0; j < 12; j++) begin
      in_data = DATA_W'('h100 + j);
      check_eq($sformatf("wrap%0d out_data", j), 32'(out_data),
               (j < 2) ? 32'('hA0 + j) : 32'('h100 + j - 2));
      step();
      check_eq($sformatf("wrap%0d count", j), 32'(count), 32'd2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Full plus pop: bring to 5, then push and pop together for one cycle
    for (int i = 0; i < 3; i++) begin
      in_data  = DATA_W'('h200 + i);
      in_valid = 1'b1;
      step();
    end
    check_eq("full count", 32'(count), 32'd5);
    check_eq("full in_ready", 32'(in_ready), 32'd0);
    in_data   = DATA_W'('h2FF);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check_eq("fullpop head", 32'(out_data), 32'h10A);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("fullpop count", 32'(count), 32'd4);
    check_eq("fullpop in_ready", 32'(in_ready), 32'd1);
    // Remaining words must not include the refused 0x2FF
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("tail%0d out_data", k), 32'(out_data), 32'(tail_exp[k]));
      step();
    end
    check_eq("tail out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Mid-operation reset at count=3
    for (int i = 0; i < 3; i++) begin
      in_data  = DATA_W'('h300 + i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check_eq("pre-rst count", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async rst out_valid", 32'(out_valid), 32'd0);
    check_eq("async rst count",     32'(count),     32'd0);
    check_eq("async rst in_ready",  32'(in_ready),  32'd1);
    step();
    #3 rst_n = 1'b1;
    step();
    in_data  = DATA_W'('hABC);
    in_valid = 1'b1;
    check_eq("no bypass out_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    check_eq("post-rst out_valid", 32'(out_valid), 32'd1);
    check_eq("post-rst out_data",  32'(out_data),  32'hABC);
    check_eq("post-rst count",     32'(count),     32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock first-word-fall-through FIFO with valid/ready handshakes on both sides, for any positive depth (power of two not required). It is the first storage primitive built on the `sizing` package: address and occupancy widths come from `encoding_size` and `bit_size`, so only `DATA_W` and `DEPTH` need to be set. It sits between stream producers and consumers (e.g. AXI-Stream stages) wherever rate decoupling or buffering is needed.

## Interface

Parameters:
- `DATA_W`, default 8: payload width in bits, ≥1.
- `DEPTH`, default 16: number of entries, ≥1, any integer.
- `AFULL_THRESH`, default `DEPTH`: `almost_full` asserts when count ≥ this value; legal range 1..`DEPTH`.

Ports:
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in `DATA_W`: write payload.
- `in_valid` in 1: write request.
- `in_ready` out 1: FIFO can accept a word.
- `out_data` out `DATA_W`: head-of-queue payload; valid only when `out_valid`=1.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer takes the head word.
- `count` out `bit_size(DEPTH)`: current occupancy, 0..`DEPTH`.
- `almost_full` out 1: count ≥ `AFULL_THRESH`.

## Operation

- Local widths: `AW = encoding_size(DEPTH)`, `CW = bit_size(DEPTH)`.
- State: storage array `[DEPTH][DATA_W]`, write pointer `wr_ptr` (AW bits), read pointer `rd_ptr` (AW bits), occupancy register `count` (CW bits).
- Push when `in_valid && in_ready`: write `in_data` at `wr_ptr`, then advance `wr_ptr`.
- Pop when `out_valid && out_ready`: advance `rd_ptr`.
- Pointer advance wraps explicitly from `DEPTH-1` to 0. Modulo-2^AW wrap is forbidden, so non-power-of-two depths are correct.
- `count` update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Flag and data outputs:
  - `in_ready = (count != DEPTH)`. It depends only on registered state, with no combinational path from `out_ready`.
  - `out_valid = (count != 0)`.
  - `out_data = mem[rd_ptr]`, read combinationally (FWFT).
  - `almost_full` is decoded from the `count` register.
- Boundary conditions:
  - Full with `in_valid`=1: no write, and the data is not captured.
  - Full with simultaneous pop: the pop happens and the write is refused that cycle.
  - Empty with `out_ready`=1: no pop. `out_data` is don't-care.
  - Empty with simultaneous push: the word is written, but `out_valid` rises only the next cycle. There is no bypass.
  - `DEPTH`=1: AW=1, and both pointers toggle between 0 and 0, i.e. they stay 0.
- Reset, asserted at any time including mid-operation:
  - Takes effect immediately, without a clock edge.
  - Clears `wr_ptr`, `rd_ptr` and `count`. The stored contents are lost.
  - Storage array is not reset.
  - Reset output values: `in_ready`=1, `out_valid`=0, `count`=0, `almost_full`=0.
- Parameter checks: an elaboration-time `$error` if `DEPTH`<1, `DATA_W`<1, or `AFULL_THRESH` is outside 1..`DEPTH`.

## Timing

- Write-to-read latency: a word pushed at edge N is visible on `out_data` with `out_valid`=1 after edge N (cycle N+1), provided it is at the head.
- Pop at edge N: the next word is presented in cycle N+1.
- `count`, `in_ready`, `out_valid` and `almost_full` change only on rising edges, or asynchronously on reset.
- Sustained throughput: one push and one pop per cycle whenever 0 < count < `DEPTH`.

## Structure

- Uses `sizing::encoding_size` and `sizing::bit_size` for `AW` and `CW`. No new functions are needed.
- No new typedefs in a shared package.
- Pointer increment-with-wrap is a local automatic function.
- Storage stays inline as a register array; no sub-module is warranted.

## Test plan

Configuration: `DATA_W`=12, `DEPTH`=5, `AFULL_THRESH`=4.

- **Reset:** hold `rst_n`=0, then release → `in_ready`=1, `out_valid`=0, `count`=0, `almost_full`=0.
- **Fill:** push 0x001..0x006 back-to-back with `out_ready`=0 → `count` steps 1..5 and `almost_full` rises when `count`=4. `in_ready`=0 once `count`=5, and 0x006 is not stored (`count` stays 5).
- **Drain:** then `out_ready`=1 continuously → `out_data` = 0x001..0x005 on consecutive cycles. `out_valid` falls after the fifth pop, `count`=0, `almost_full` clears when `count` drops to 3.
- **Wrap:** preload 2 words, then 12 cycles of simultaneous push/pop of 0x100..0x10B → `count` stays 2 and output order is preserved across pointer wrap at index 4.
- **Full plus pop:** at `count`=5 drive `in_valid`=1 and `out_ready`=1 for one cycle → head word popped, no write, next cycle `count`=4 and `in_ready`=1.
- **Mid-operation reset:** at `count`=3, drop `rst_n` between clock edges → `out_valid`=0, `count`=0, `in_ready`=1 immediately. After release, the first push 0xABC appears on `out_data` one cycle later.
